// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-rate divider, h/v raster counters, sync/active/coordinate
// outputs and a per-frame motion strobe for the object stages.
module vga_timing_gen #(
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter int unsigned UPDATE_DIV = 1
) (
    input  logic       clk,
    input  logic       rst,
    output logic       hsync,
    output logic       vsync,
    output logic       active,
    output logic [9:0] xLength,
    output logic [9:0] yLength,
    output logic       pix_en,
    output logic       update
);

    localparam int unsigned CNT_W        = 10;
    localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
    localparam int unsigned H_SYNC_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
    localparam int unsigned V_SYNC_END   = V_ACTIVE + V_FP + V_SYNC;
    localparam int unsigned DIV_W        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned FRM_W        = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;

    // Scan state
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic [FRM_W-1:0] frame_cnt_q, frame_cnt_d;

    // Registered outputs
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             active_q, active_d;
    logic [CNT_W-1:0] x_q, x_d;
    logic [CNT_W-1:0] y_q, y_d;
    logic             pix_en_q, pix_en_d;
    logic             update_q, update_d;

    logic             pix_tick;
    logic             h_wrap;
    logic             v_wrap;
    logic             frame_last;
    logic [31:0]      h_ext;
    logic [31:0]      v_ext;

    // Divider: pixel tick on the last count of each CLK_DIV window (always for CLK_DIV=1)
    always_comb begin
        pix_tick  = (div_cnt_q == DIV_W'(CLK_DIV - 1));
        div_cnt_d = div_cnt_q + DIV_W'(1);
        if (pix_tick) begin
            div_cnt_d = '0;
        end
    end

    // Raster counters: h advances per pixel tick, v on h wrap, frame count on v wrap
    always_comb begin
        h_wrap      = (h_cnt_q == CNT_W'(H_TOTAL - 1));
        v_wrap      = (v_cnt_q == CNT_W'(V_TOTAL - 1));
        frame_last  = (frame_cnt_q == FRM_W'(UPDATE_DIV - 1));
        h_cnt_d     = h_cnt_q;
        v_cnt_d     = v_cnt_q;
        frame_cnt_d = frame_cnt_q;
        if (pix_tick) begin
            h_cnt_d = h_wrap ? '0 : h_cnt_q + CNT_W'(1);
            if (h_wrap) begin
                v_cnt_d = v_wrap ? '0 : v_cnt_q + CNT_W'(1);
                if (v_wrap) begin
                    frame_cnt_d = frame_last ? '0 : frame_cnt_q + FRM_W'(1);
                end
            end
        end
    end

    // Output decode from the current counters; registered one clock later
    always_comb begin
        h_ext    = 32'(h_cnt_q);
        v_ext    = 32'(v_cnt_q);
        x_d      = h_cnt_q;
        y_d      = v_cnt_q;
        hsync_d  = !((h_ext >= H_SYNC_START) && (h_ext < H_SYNC_END));
        vsync_d  = !((v_ext >= V_SYNC_START) && (v_ext < V_SYNC_END));
        active_d = (h_ext < H_ACTIVE) && (v_ext < V_ACTIVE);
        update_d = (v_ext == V_ACTIVE) && frame_last;
        pix_en_d = pix_tick;
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q   <= '0;
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            frame_cnt_q <= '0;
            hsync_q     <= 1'b1;
            vsync_q     <= 1'b1;
            active_q    <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            pix_en_q    <= 1'b0;
            update_q    <= 1'b0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            active_q    <= active_d;
            x_q         <= x_d;
            y_q         <= y_d;
            pix_en_q    <= pix_en_d;
            update_q    <= update_d;
        end
    end

    assign hsync   = hsync_q;
    assign vsync   = vsync_q;
    assign active  = active_q;
    assign xLength = x_q;
    assign yLength = y_q;
    assign pix_en  = pix_en_q;
    assign update  = update_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: four instances (full VGA timing and three reduced rasters) compared
// every clock against an arithmetic raster model derived from elapsed clocks since reset.
module tb_vga_timing_gen;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       act;
        logic       pe;
        logic       upd;
        logic [9:0] x;
        logic [9:0] y;
    } obs_t;

    logic clk;
    logic rst;

    logic       hs0, vs0, act0, pe0, upd0;
    logic [9:0] x0, y0;
    logic       hs1, vs1, act1, pe1, upd1;
    logic [9:0] x1, y1;
    logic       hs2, vs2, act2, pe2, upd2;
    logic [9:0] x2, y2;
    logic       hs3, vs3, act3, pe3, upd3;
    logic [9:0] x3, y3;

    int errors = 0;
    int checks = 0;
    int k      = 0;
    int hs_low0 = 0;
    int act_hi0 = 0;
    int rises1 = 0, mrises1 = 0, rises2 = 0, mrises2 = 0;
    logic pu1 = 1'b0, pmu1 = 1'b0, pu2 = 1'b0, pmu2 = 1'b0;

    // Full 640x480 timing, default divider
    vga_timing_gen dut0 (.clk(clk), .rst(rst), .hsync(hs0), .vsync(vs0), .active(act0),
                         .xLength(x0), .yLength(y0), .pix_en(pe0), .update(upd0));

    // Reduced raster, CLK_DIV=2, H 16/2/4/2, V 8/2/2/3
    vga_timing_gen #(.CLK_DIV(2), .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
                     .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3), .UPDATE_DIV(1))
        dut1 (.clk(clk), .rst(rst), .hsync(hs1), .vsync(vs1), .active(act1),
              .xLength(x1), .yLength(y1), .pix_en(pe1), .update(upd1));

    // Reduced raster, CLK_DIV=3, update every third frame
    vga_timing_gen #(.CLK_DIV(3), .H_ACTIVE(12), .H_FP(3), .H_SYNC(5), .H_BP(4),
                     .V_ACTIVE(6), .V_FP(2), .V_SYNC(3), .V_BP(2), .UPDATE_DIV(3))
        dut2 (.clk(clk), .rst(rst), .hsync(hs2), .vsync(vs2), .active(act2),
              .xLength(x2), .yLength(y2), .pix_en(pe2), .update(upd2));

    // CLK_DIV=1 with H 8/2/2/2, V 4/1/1/1
    vga_timing_gen #(.CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
                     .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .UPDATE_DIV(1))
        dut3 (.clk(clk), .rst(rst), .hsync(hs3), .vsync(vs3), .active(act3),
              .xLength(x3), .yLength(y3), .pix_en(pe3), .update(upd3));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected outputs kc clocks after the reset edge: pixel index = (kc-1)/cdiv
    function automatic obs_t model(input int ha, input int hf, input int hw, input int hb,
                                   input int va, input int vf, input int vw, input int vb,
                                   input int cd, input int ud, input int kc);
        obs_t o;
        int ht, vt, p, x, y, f;
        if (kc == 0) begin
            o = '{hs: 1'b1, vs: 1'b1, act: 1'b0, pe: 1'b0, upd: 1'b0, x: 10'd0, y: 10'd0};
            return o;
        end
        ht    = ha + hf + hw + hb;
        vt    = va + vf + vw + vb;
        p     = (kc - 1) / cd;
        x     = p % ht;
        y     = (p / ht) % vt;
        f     = p / (ht * vt);
        o.x   = 10'(x);
        o.y   = 10'(y);
        o.hs  = !((x >= ha + hf) && (x < ha + hf + hw));
        o.vs  = !((y >= va + vf) && (y < va + vf + vw));
        o.act = (x < ha) && (y < va);
        o.pe  = (((kc - 1) % cd) == cd - 1);
        o.upd = (y == va) && ((f % ud) == ud - 1);
        return o;
    endfunction

    function automatic obs_t pack(input logic hs, input logic vs, input logic act,
                                  input logic pe, input logic upd,
                                  input logic [9:0] x, input logic [9:0] y);
        obs_t o;
        o = '{hs: hs, vs: vs, act: act, pe: pe, upd: upd, x: x, y: y};
        return o;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s k=%0d observed=%0d expected=%0d", tag, k, got, exp);
        end
    endtask

    task automatic chk_dut(input string name, input obs_t g, input obs_t e);
        chk({name, ".hsync"},   32'(g.hs),  32'(e.hs));
        chk({name, ".vsync"},   32'(g.vs),  32'(e.vs));
        chk({name, ".active"},  32'(g.act), 32'(e.act));
        chk({name, ".pix_en"},  32'(g.pe),  32'(e.pe));
        chk({name, ".update"},  32'(g.upd), 32'(e.upd));
        chk({name, ".xLength"}, 32'(g.x),   32'(e.x));
        chk({name, ".yLength"}, 32'(g.y),   32'(e.y));
    endtask

    // One clock: advance the model clock count and compare every instance
    task automatic step();
        obs_t e0, e1, e2, e3;
        @(posedge clk);
        #1;
        if (rst) k = 0;
        else     k++;
        e0 = model(640, 16, 96, 48, 480, 10, 2, 33, 2, 1, k);
        e1 = model(16, 2, 4, 2, 8, 2, 2, 3, 2, 1, k);
        e2 = model(12, 3, 5, 4, 6, 2, 3, 2, 3, 3, k);
        e3 = model(8, 2, 2, 2, 4, 1, 1, 1, 1, 1, k);
        chk_dut("d0", pack(hs0, vs0, act0, pe0, upd0, x0, y0), e0);
        chk_dut("d1", pack(hs1, vs1, act1, pe1, upd1, x1, y1), e1);
        chk_dut("d2", pack(hs2, vs2, act2, pe2, upd2, x2, y2), e2);
        chk_dut("d3", pack(hs3, vs3, act3, pe3, upd3, x3, y3), e3);
        if (k >= 1 && k <= 1600) begin
            if (hs0 === 1'b0) hs_low0++;
            if (act0 === 1'b1) act_hi0++;
        end
        if (upd1 === 1'b1 && pu1 === 1'b0) rises1++;
        if (e1.upd && !pmu1) mrises1++;
        if (upd2 === 1'b1 && pu2 === 1'b0) rises2++;
        if (e2.upd && !pmu2) mrises2++;
        pu1  = upd1;
        pmu1 = e1.upd;
        pu2  = upd2;
        pmu2 = e2.upd;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        run(cycles);
        rst = 1'b0;
    endtask

    initial begin
        int hold;
        int len;
        rst = 1'b1;
        run(2);
        rst = 1'b0;

        // First full line of the 640x480 raster
        run(1600);
        chk("d0.first_line_hsync_low_clks", 32'(hs_low0), 32'd192);
        chk("d0.first_line_active_clks",    32'(act_hi0), 32'd1280);

        // Many reduced frames: wraps, sync windows, update cadence
        run(28400);
        chk("d1.update_rises", 32'(rises1), 32'(mrises1));
        chk("d2.update_rises", 32'(rises2), 32'(mrises2));

        // Mid-frame reset with d1 at (x=10,y=5)
        do_reset(1);
        run(261);
        chk("d1.pre_reset_x", 32'(x1), 32'd10);
        chk("d1.pre_reset_y", 32'(y1), 32'd5);
        do_reset(1);
        run(500);

        // Randomized reset points and hold lengths
        for (int i = 0; i < 4; i++) begin
            hold = int'($urandom_range(3, 1));
            len  = int'($urandom_range(5000, 50));
            do_reset(hold);
            run(len);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
